// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arith/shift ops plus iterative MUL/DIV into HI/LO.
// Latency: 1 edge for combinational ops, W edges for MULT/MULTU/DIV/DIVU.
// Backpressure: In_Ready drops while a MUL/DIV iterates; requests are held by the requester.
module alu_seq #(
    parameter int W        = 32,
    parameter int CTRL_LEN = 5,
    parameter int SH_LEN   = 5
) (
    input  logic                Clk,
    input  logic                Rst_n,
    input  logic                In_Valid,
    output logic                In_Ready,
    input  logic [W-1:0]        Op1,
    input  logic [W-1:0]        Op2,
    input  logic [CTRL_LEN-1:0] ALUCtrl,
    input  logic                Flush,
    output logic                Out_Valid,
    output logic [W-1:0]        Res,
    output logic                Overflow,
    output logic [W-1:0]        Hi,
    output logic [W-1:0]        Lo
);

    localparam logic [CTRL_LEN-1:0] OP_ADD   = CTRL_LEN'(0);
    localparam logic [CTRL_LEN-1:0] OP_SUB   = CTRL_LEN'(1);
    localparam logic [CTRL_LEN-1:0] OP_ADDU  = CTRL_LEN'(2);
    localparam logic [CTRL_LEN-1:0] OP_SUBU  = CTRL_LEN'(3);
    localparam logic [CTRL_LEN-1:0] OP_AND   = CTRL_LEN'(4);
    localparam logic [CTRL_LEN-1:0] OP_OR    = CTRL_LEN'(5);
    localparam logic [CTRL_LEN-1:0] OP_XOR   = CTRL_LEN'(6);
    localparam logic [CTRL_LEN-1:0] OP_NOR   = CTRL_LEN'(7);
    localparam logic [CTRL_LEN-1:0] OP_SLT   = CTRL_LEN'(8);
    localparam logic [CTRL_LEN-1:0] OP_SLTU  = CTRL_LEN'(9);
    localparam logic [CTRL_LEN-1:0] OP_SLL   = CTRL_LEN'(10);
    localparam logic [CTRL_LEN-1:0] OP_SRL   = CTRL_LEN'(11);
    localparam logic [CTRL_LEN-1:0] OP_SRA   = CTRL_LEN'(12);
    localparam logic [CTRL_LEN-1:0] OP_MFHI  = CTRL_LEN'(13);
    localparam logic [CTRL_LEN-1:0] OP_MFLO  = CTRL_LEN'(14);
    localparam logic [CTRL_LEN-1:0] OP_MULT  = CTRL_LEN'(15);
    localparam logic [CTRL_LEN-1:0] OP_MULTU = CTRL_LEN'(16);
    localparam logic [CTRL_LEN-1:0] OP_DIV   = CTRL_LEN'(17);
    localparam logic [CTRL_LEN-1:0] OP_DIVU  = CTRL_LEN'(18);

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t            state, state_nxt;
    logic              accept, is_mul, is_div, sgn_op, last;
    logic              a_neg, b_neg;
    logic [W-1:0]      a_mag, b_mag;
    logic [W-1:0]      add_sum, sub_dif, comb_res;
    logic              comb_ovf;

    // acc_q: multiplier / dividend shifting into quotient; acc_r: partial product high / remainder
    logic [W-1:0]      acc_r, acc_q, acc_d;
    logic [SH_LEN-1:0] cnt;
    logic              neg_q, neg_r, div0;
    logic [W-1:0]      op1_raw;

    logic [W:0]        mul_sum, div_sh, div_diff;
    logic              div_ge;
    logic [W-1:0]      mul_r_nxt, mul_q_nxt, div_r_nxt, div_q_nxt;
    logic [2*W-1:0]    prod_mag, prod;
    logic [W-1:0]      quo, rem;

    assign accept = In_Valid && In_Ready;
    assign is_mul = (ALUCtrl == OP_MULT) || (ALUCtrl == OP_MULTU);
    assign is_div = (ALUCtrl == OP_DIV) || (ALUCtrl == OP_DIVU);
    assign sgn_op = (ALUCtrl == OP_MULT) || (ALUCtrl == OP_DIV);
    assign last   = (cnt == SH_LEN'(W - 1));

    always_comb begin
        a_neg = sgn_op & Op1[W-1];
        b_neg = sgn_op & Op2[W-1];
        a_mag = a_neg ? -Op1 : Op1;
        b_mag = b_neg ? -Op2 : Op2;
    end

    always_comb begin
        add_sum  = Op1 + Op2;
        sub_dif  = Op1 - Op2;
        comb_res = '0;
        comb_ovf = 1'b0;
        case (ALUCtrl)
            OP_ADD: begin
                comb_res = add_sum;
                comb_ovf = (Op1[W-1] == Op2[W-1]) && (add_sum[W-1] != Op1[W-1]);
            end
            OP_SUB: begin
                comb_res = sub_dif;
                comb_ovf = (Op1[W-1] != Op2[W-1]) && (sub_dif[W-1] != Op1[W-1]);
            end
            OP_ADDU: comb_res = add_sum;
            OP_SUBU: comb_res = sub_dif;
            OP_AND:  comb_res = Op1 & Op2;
            OP_OR:   comb_res = Op1 | Op2;
            OP_XOR:  comb_res = Op1 ^ Op2;
            OP_NOR:  comb_res = ~(Op1 | Op2);
            OP_SLT:  comb_res[0] = $signed(Op1) < $signed(Op2);
            OP_SLTU: comb_res[0] = Op1 < Op2;
            OP_SLL:  comb_res = Op2 << Op1[SH_LEN-1:0];
            OP_SRL:  comb_res = Op2 >> Op1[SH_LEN-1:0];
            OP_SRA:  comb_res = $unsigned($signed(Op2) >>> Op1[SH_LEN-1:0]);
            OP_MFHI: comb_res = Hi;
            OP_MFLO: comb_res = Lo;
            default: comb_res = '0;
        endcase
    end

    // One shift-add step and one restoring-divide step; the last step feeds HI/LO directly
    always_comb begin
        mul_sum   = {1'b0, acc_r} + (acc_q[0] ? {1'b0, acc_d} : '0);
        mul_r_nxt = mul_sum[W:1];
        mul_q_nxt = {mul_sum[0], acc_q[W-1:1]};
        div_sh    = {acc_r, acc_q[W-1]};
        div_diff  = div_sh - {1'b0, acc_d};
        div_ge    = ~div_diff[W];
        div_r_nxt = div_ge ? div_diff[W-1:0] : div_sh[W-1:0];
        div_q_nxt = {acc_q[W-2:0], div_ge};
        prod_mag  = {mul_r_nxt, mul_q_nxt};
        prod      = neg_q ? -prod_mag : prod_mag;
        quo       = div0 ? '1 : (neg_q ? -div_q_nxt : div_q_nxt);
        rem       = div0 ? op1_raw : (neg_r ? -div_r_nxt : div_r_nxt);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        In_Ready  = 1'b0;
        case (state)
            IDLE: begin
                In_Ready = 1'b1;
                if (accept && is_mul)      state_nxt = MUL;
                else if (accept && is_div) state_nxt = DIV;
            end
            MUL, DIV: if (Flush || last) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Res       <= '0;
            Overflow  <= 1'b0;
            Out_Valid <= 1'b0;
            Hi        <= '0;
            Lo        <= '0;
            acc_r     <= '0;
            acc_q     <= '0;
            acc_d     <= '0;
            cnt       <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            div0      <= 1'b0;
            op1_raw   <= '0;
        end else begin
            Out_Valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && (is_mul || is_div)) begin
                        acc_r   <= '0;
                        acc_q   <= a_mag;
                        acc_d   <= b_mag;
                        cnt     <= '0;
                        neg_q   <= a_neg ^ b_neg;
                        neg_r   <= a_neg;
                        div0    <= (Op2 == '0);
                        op1_raw <= Op1;
                    end else if (accept) begin
                        Res       <= comb_res;
                        Overflow  <= comb_ovf;
                        Out_Valid <= 1'b1;
                    end
                end
                MUL: begin
                    if (!Flush && last) begin
                        {Hi, Lo}  <= prod;
                        Overflow  <= 1'b0;
                        Out_Valid <= 1'b1;
                    end else if (!Flush) begin
                        acc_r <= mul_r_nxt;
                        acc_q <= mul_q_nxt;
                        cnt   <= cnt + SH_LEN'(1);
                    end
                end
                DIV: begin
                    if (!Flush && last) begin
                        Hi        <= rem;
                        Lo        <= quo;
                        Overflow  <= 1'b0;
                        Out_Valid <= 1'b1;
                    end else if (!Flush) begin
                        acc_r <= div_r_nxt;
                        acc_q <= div_q_nxt;
                        cnt   <= cnt + SH_LEN'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Randomised and directed bench for alu_seq with a queue scoreboard fed by an arithmetic model.
module tb_alu_seq;
    localparam int W = 32;

    logic          Clk = 1'b0;
    logic          Rst_n = 1'b0;
    logic          In_Valid = 1'b0;
    logic          Flush = 1'b0;
    logic [W-1:0]  Op1 = '0;
    logic [W-1:0]  Op2 = '0;
    logic [4:0]    ALUCtrl = '0;
    logic          In_Ready, Out_Valid, Overflow;
    logic [W-1:0]  Res, Hi, Lo;

    alu_seq #(.W(W), .CTRL_LEN(5), .SH_LEN(5)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .In_Valid(In_Valid), .In_Ready(In_Ready),
        .Op1(Op1), .Op2(Op2), .ALUCtrl(ALUCtrl), .Flush(Flush),
        .Out_Valid(Out_Valid), .Res(Res), .Overflow(Overflow), .Hi(Hi), .Lo(Lo)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_res = '0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Reference behaviour from plain integer arithmetic; updates the architectural model
    function automatic exp_t model(logic [4:0] op, logic [31:0] a, logic [31:0] b);
        exp_t        e;
        longint      s;
        logic [63:0] p;
        logic        ovf;
        int          sa, sb_;
        sa  = $signed(a);
        sb_ = $signed(b);
        ovf = 1'b0;
        case (op)
            5'd0:  begin m_res = a + b; s = longint'(sa) + longint'(sb_); ovf = (s != longint'($signed(m_res))); end
            5'd1:  begin m_res = a - b; s = longint'(sa) - longint'(sb_); ovf = (s != longint'($signed(m_res))); end
            5'd2:  m_res = a + b;
            5'd3:  m_res = a - b;
            5'd4:  m_res = a & b;
            5'd5:  m_res = a | b;
            5'd6:  m_res = a ^ b;
            5'd7:  m_res = ~(a | b);
            5'd8:  m_res = (sa < sb_) ? 32'd1 : 32'd0;
            5'd9:  m_res = (a < b) ? 32'd1 : 32'd0;
            5'd10: m_res = b << a[4:0];
            5'd11: m_res = b >> a[4:0];
            5'd12: m_res = sb_ >>> a[4:0];
            5'd13: m_res = m_hi;
            5'd14: m_res = m_lo;
            5'd15: begin p = longint'(sa) * longint'(sb_); {m_hi, m_lo} = p; end
            5'd16: begin p = {32'd0, a} * {32'd0, b}; {m_hi, m_lo} = p; end
            5'd17: begin
                if (b == 32'd0) begin m_lo = 32'hFFFFFFFF; m_hi = a; end
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin m_lo = 32'h80000000; m_hi = 32'd0; end
                else begin m_lo = sa / sb_; m_hi = sa % sb_; end
            end
            5'd18: begin
                if (b == 32'd0) begin m_lo = 32'hFFFFFFFF; m_hi = a; end
                else begin m_lo = a / b; m_hi = a % b; end
            end
            default: m_res = 32'd0;
        endcase
        e.res = m_res;
        e.ovf = ovf;
        e.hi  = m_hi;
        e.lo  = m_lo;
        return e;
    endfunction

    always @(negedge Clk) begin
        exp_t e;
        if (Rst_n && Out_Valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out_valid: got Out_Valid=1 expected no pending op");
            end else begin
                e = sb.pop_front();
                chk("sb_res", {32'd0, Res}, {32'd0, e.res});
                chk("sb_ovf", {63'd0, Overflow}, {63'd0, e.ovf});
                chk("sb_hi", {32'd0, Hi}, {32'd0, e.hi});
                chk("sb_lo", {32'd0, Lo}, {32'd0, e.lo});
            end
        end
    end

    // Called at a falling edge; holds the request until accepted, returns at the next falling edge
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input bit track);
        int guard;
        In_Valid = 1'b1;
        ALUCtrl  = op;
        Op1      = a;
        Op2      = b;
        guard    = 0;
        while (!In_Ready && guard < 100) begin
            @(negedge Clk);
            guard++;
        end
        if (!In_Ready) chk("issue_ready_timeout", {63'd0, In_Ready}, 64'd1);
        if (track) sb.push_back(model(op, a, b));
        @(posedge Clk);
        @(negedge Clk);
        In_Valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!Out_Valid && n < 80) begin
            @(negedge Clk);
            n++;
        end
        chk(name, {63'd0, Out_Valid}, 64'd1);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 9))
            0: return 32'h00000000;
            1: return 32'h00000001;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            4: return 32'h7FFFFFFF;
            default: return $urandom();
        endcase
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int lat, busy, ovc;
        logic [4:0] op;

        #12;
        chk("rst_res", {32'd0, Res}, 64'd0);
        chk("rst_vld", {63'd0, Out_Valid}, 64'd0);
        chk("rst_ovf", {63'd0, Overflow}, 64'd0);
        chk("rst_hi", {32'd0, Hi}, 64'd0);
        chk("rst_lo", {32'd0, Lo}, 64'd0);
        chk("rst_rdy", {63'd0, In_Ready}, 64'd1);
        @(negedge Clk);
        Rst_n = 1'b1;

        issue(5'd0, 32'h7FFFFFFF, 32'h00000001, 1'b1);
        chk("add_vld", {63'd0, Out_Valid}, 64'd1);
        chk("add_res", {32'd0, Res}, 64'h80000000);
        chk("add_ovf", {63'd0, Overflow}, 64'd1);
        issue(5'd2, 32'h7FFFFFFF, 32'h00000001, 1'b1);
        chk("addu_ovf", {63'd0, Overflow}, 64'd0);

        issue(5'd12, 32'd4, 32'h80000000, 1'b1);
        chk("b2b_rdy1", {63'd0, In_Ready}, 64'd1);
        chk("sra_res", {32'd0, Res}, 64'hF8000000);
        issue(5'd9, 32'hFFFFFFFF, 32'd1, 1'b1);
        chk("b2b_rdy2", {63'd0, In_Ready}, 64'd1);
        chk("b2b_vld2", {63'd0, Out_Valid}, 64'd1);
        chk("sltu_res", {32'd0, Res}, 64'd0);

        issue(5'd15, 32'hFFFFFFFD, 32'd5, 1'b1);
        lat  = 0;
        busy = 0;
        while (!Out_Valid && lat < 60) begin
            if (!In_Ready) busy++;
            @(negedge Clk);
            lat++;
        end
        chk("mult_latency", 64'(lat), 64'd32);
        chk("mult_busy", 64'(busy), 64'd32);
        chk("mult_hi", {32'd0, Hi}, 64'hFFFFFFFF);
        chk("mult_lo", {32'd0, Lo}, 64'hFFFFFFF1);
        issue(5'd14, 32'd0, 32'd0, 1'b1);
        chk("mflo_res", {32'd0, Res}, 64'hFFFFFFF1);

        issue(5'd17, 32'd7, 32'hFFFFFFFE, 1'b1);
        wait_done("div_done");
        chk("div_lo", {32'd0, Lo}, 64'hFFFFFFFD);
        chk("div_hi", {32'd0, Hi}, 64'h00000001);
        issue(5'd17, 32'h80000000, 32'hFFFFFFFF, 1'b1);
        wait_done("divmin_done");
        chk("divmin_lo", {32'd0, Lo}, 64'h80000000);
        chk("divmin_hi", {32'd0, Hi}, 64'd0);
        issue(5'd18, 32'd9, 32'd0, 1'b1);
        wait_done("divu0_done");
        chk("divu0_lo", {32'd0, Lo}, 64'hFFFFFFFF);
        chk("divu0_hi", {32'd0, Hi}, 64'h00000009);

        issue(5'd16, 32'hFFFFFFFF, 32'd2, 1'b0);
        repeat (9) @(negedge Clk);
        Flush = 1'b1;
        @(negedge Clk);
        Flush = 1'b0;
        chk("flush_rdy", {63'd0, In_Ready}, 64'd1);
        chk("flush_hi", {32'd0, Hi}, {32'd0, m_hi});
        chk("flush_lo", {32'd0, Lo}, {32'd0, m_lo});
        ovc = 0;
        repeat (40) begin
            @(negedge Clk);
            if (Out_Valid) ovc++;
        end
        chk("flush_no_vld", 64'(ovc), 64'd0);

        Flush = 1'b1;
        issue(5'd0, 32'd5, 32'd6, 1'b1);
        Flush = 1'b0;
        chk("flush_idle_res", {32'd0, Res}, 64'd11);

        issue(5'd17, 32'd100, 32'd7, 1'b0);
        repeat (5) @(negedge Clk);
        #2;
        Rst_n = 1'b0;
        #1;
        chk("arst_res", {32'd0, Res}, 64'd0);
        chk("arst_hi", {32'd0, Hi}, 64'd0);
        chk("arst_lo", {32'd0, Lo}, 64'd0);
        chk("arst_vld", {63'd0, Out_Valid}, 64'd0);
        chk("arst_ovf", {63'd0, Overflow}, 64'd0);
        @(negedge Clk);
        Rst_n = 1'b1;
        m_res = '0;
        m_hi  = '0;
        m_lo  = '0;
        chk("arst_rdy", {63'd0, In_Ready}, 64'd1);

        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 99) < 20) op = 5'($urandom_range(15, 18));
            else                            op = 5'($urandom_range(0, 31));
            issue(op, pick(), pick(), 1'b1);
            repeat ($urandom_range(0, 2)) @(negedge Clk);
        end
        repeat (80) @(negedge Clk);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised sequential successor to the datapath's combinational ALU. Adds a registered output, a valid/ready handshake and an extended op set.
- Adds iterative MULT/MULTU/DIV/DIVU that write dedicated HI/LO registers, plus MFHI/MFLO reads.
- Sits in the EX stage. The pipeline stalls while In_Ready is low.

Parameters:
- W, 32: operand/result width. Must be even and at least 8.
- CTRL_LEN, 5: ALUCtrl width.
- SH_LEN, 5: shift-amount bits. Must equal log2(W).

Ports:
- Clk, input, 1: clock, rising edge.
- Rst_n, input, 1: asynchronous active-low reset.
- In_Valid, input, 1: op request. Accepted when In_Valid and In_Ready are both high on a rising edge.
- In_Ready, output, 1: high only in state IDLE.
- Op1, input, W: operand 1. Also the shift amount source, low SH_LEN bits.
- Op2, input, W: operand 2. Also the shifted value.
- ALUCtrl, input, CTRL_LEN: opcode.
- Flush, input, 1: synchronous abort of an in-flight MUL/DIV.
- Out_Valid, output, 1: one-cycle pulse marking a completed op.
- Res, output, W: registered result. Held until the next completion.
- Overflow, output, 1: signed overflow of ADD/SUB. Valid with Out_Valid.
- Hi, output, W: HI register.
- Lo, output, W: LO register.

Behaviour:
- Opcodes, all combinational class unless noted:
  - 0 ADD, 1 SUB, 2 ADDU, 3 SUBU, 4 AND, 5 OR, 6 XOR, 7 NOR.
  - 8 SLT, signed. 9 SLTU, unsigned.
  - 10 SLL, 11 SRL, 12 SRA: Op2 shifted by Op1[SH_LEN-1:0].
  - 13 MFHI, 14 MFLO.
  - 15 MULT, 16 MULTU, 17 DIV, 18 DIVU: iterative class.
  - 19-31 undefined: treated as a combinational op with Res=0, Overflow=0.
- Reset values: state=IDLE, Res=0, Overflow=0, Out_Valid=0, Hi=0, Lo=0, counter=0, internal accumulators=0.
- States:
  - IDLE. Accept of a combinational op -> stays IDLE. Next edge: Res and Overflow load, Out_Valid=1. Latency 1; back-to-back issue every cycle.
  - IDLE, accept MULT/MULTU -> MUL. Accept DIV/DIVU -> DIV. Operands latched. Signed ops convert operands to magnitudes and record the result signs. Counter=0.
  - MUL: radix-2 shift-add, one bit per cycle, W cycles.
  - DIV: restoring divide, one quotient bit per cycle, W cycles.
  - Final iteration cycle (counter=W-1): the next edge writes Hi/Lo with sign correction, pulses Out_Valid, leaves Res unchanged, sets Overflow=0 and returns to IDLE. Accept-to-Out_Valid latency is W edges.
- Arithmetic:
  - ADD/SUB: W-bit wrap result. Overflow=1 when the operand signs cause signed overflow.
  - ADDU/SUBU: Overflow is always 0.
  - SLT/SLTU: Res = zero-extended 1 or 0.
  - SRA: replicates Op2[W-1].
  - MULT/MULTU: {Hi,Lo} = 2W-bit product.
  - DIV/DIVU: Lo = quotient truncated toward zero, Hi = remainder with the sign of the dividend.
  - Divide by zero, signed and unsigned: Lo = all ones, Hi = Op1. No exception.
  - DIV of most-negative / -1: Lo = most-negative, Hi = 0.
- MFHI/MFLO: Res = Hi/Lo as held at accept.
- Flush:
  - In MUL/DIV: next edge returns to IDLE. Hi/Lo unchanged, no Out_Valid.
  - In IDLE: no effect.
  - When Flush and In_Valid are high in the same IDLE cycle, the request is still accepted.
- In_Valid while In_Ready=0: ignored. The requester must hold the request.
- Rst_n low in any state: immediate return to reset values. A partial MUL/DIV result is discarded.
- Out_Valid is never asserted two consecutive cycles for the same op.

Test Plan:
- Reset, then ADD 0x7FFFFFFF + 0x00000001 -> next cycle Out_Valid=1, Res=0x80000000, Overflow=1. ADDU of the same operands -> Overflow=0.
- Back-to-back issue SRA (Op1=4, Op2=0x80000000), then SLTU (0xFFFFFFFF, 1) -> Res=0xF8000000 on the first completion, then Res=0 on the next cycle. In_Ready stays 1 throughout.
- MULT -3 × 5, i.e. 0xFFFFFFFD × 5:
  - In_Ready=0 for 32 cycles.
  - Out_Valid exactly 32 edges after accept.
  - Hi=0xFFFFFFFF, Lo=0xFFFFFFF1.
  - Then MFLO -> Res=0xFFFFFFF1.
- DIV 7 / -2 -> Lo=0xFFFFFFFD, Hi=0x00000001.
- DIVU 9 / 0 -> Lo=0xFFFFFFFF, Hi=0x00000009.
- DIV 0x80000000 / 0xFFFFFFFF -> Lo=0x80000000, Hi=0.
- Abort and reset: start MULTU 0xFFFFFFFF × 2 and Flush at cycle 10 -> IDLE next edge, no Out_Valid, Hi/Lo keep prior values. Repeat with Rst_n pulsed low mid-DIV -> all outputs 0 asynchronously, In_Ready=1 after release.
